// File: rtl/morse_playback.sv
// Morse transmitter: replays 2-bit-coded words from the game RAM as a timed tone.
// Optional build macro MORSE_PLAYBACK_REPEAT_EN: loop playback with a 7-unit word gap until stop.
module morse_playback #(
  parameter int UNIT_CYCLES = 50_000_000
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       start,
  input  logic       stop,
  input  logic [3:0] count,
  input  logic [9:0] rd_data,
  output logic [3:0] rd_addr,
  output logic       rd_en,
  output logic       tone,
  output logic [1:0] symbol,
  output logic       busy,
  output logic       done
);

`ifdef MORSE_PLAYBACK_REPEAT_EN
  localparam int MAX_UNITS = 4;
`else
  localparam int MAX_UNITS = 3;
`endif
  localparam int CNT_W = $clog2(MAX_UNITS * UNIT_CYCLES);

  typedef enum logic [3:0] {
    S_IDLE,
    S_FETCH,
    S_WAIT,
    S_LOAD,
    S_MARK,
    S_GAP,
    S_WGAP,
    S_PAUSE,
    S_DONE
  } state_t;

  state_t           state_q, state_d;
  logic [3:0]       addr_q, addr_d;
  logic [3:0]       count_q;
  logic [9:0]       word_q;
  logic [2:0]       slot_q;
  logic [CNT_W-1:0] ucnt_q;
  logic             ld_cnt;
  logic [CNT_W-1:0] ld_val;
  logic             unit_end;
  logic             sym_ok;
  logic             more_words;
  logic             busy_int;

  // Down-counter reload value for a duration of n Morse units.
  function automatic logic [CNT_W-1:0] units_to_cnt(input int n);
    return CNT_W'(n * UNIT_CYCLES - 1);
  endfunction

  assign unit_end   = (ucnt_q == '0);
  assign sym_ok     = word_q[8] && (slot_q != 3'd5);
  assign more_words = ({1'b0, addr_q} + 5'd1) < {1'b0, count_q};
  assign busy_int   = (state_q != S_IDLE) && (state_q != S_DONE);

`ifdef MORSE_PLAYBACK_REPEAT_EN
  logic stop_req_q;
  logic stop_now;
  logic state_end;

  assign stop_now  = stop_req_q | stop;
  assign state_end = (state_q == S_MARK || state_q == S_GAP ||
                      state_q == S_WGAP || state_q == S_PAUSE) ? unit_end : 1'b1;
`else
  logic unused_stop;
  assign unused_stop = stop;
`endif

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    ld_cnt  = 1'b0;
    ld_val  = '0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          addr_d  = '0;
          state_d = (count != 4'd0) ? S_FETCH : S_DONE;
        end
      end
      S_FETCH: state_d = S_WAIT;
      S_WAIT:  state_d = S_LOAD;
      S_LOAD, S_GAP: begin
        if (state_q == S_LOAD || unit_end) begin
          ld_cnt = 1'b1;
          if (sym_ok) begin
            state_d = S_MARK;
            ld_val  = word_q[9] ? units_to_cnt(3) : units_to_cnt(1);
          end else begin
            state_d = S_WGAP;
            ld_val  = units_to_cnt(2);
          end
        end
      end
      S_MARK: begin
        if (unit_end) begin
          state_d = S_GAP;
          ld_cnt  = 1'b1;
          ld_val  = units_to_cnt(1);
        end
      end
      S_WGAP: begin
        if (unit_end) begin
          if (more_words) begin
            state_d = S_FETCH;
            addr_d  = addr_q + 4'd1;
          end else begin
`ifdef MORSE_PLAYBACK_REPEAT_EN
            state_d = S_PAUSE;
            ld_cnt  = 1'b1;
            ld_val  = units_to_cnt(4);
`else
            state_d = S_DONE;
`endif
          end
        end
      end
`ifdef MORSE_PLAYBACK_REPEAT_EN
      S_PAUSE: begin
        if (unit_end) begin
          state_d = S_FETCH;
          addr_d  = '0;
        end
      end
`endif
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
`ifdef MORSE_PLAYBACK_REPEAT_EN
    // A pending stop lets the current state run to completion, then exits.
    if (busy_int && stop_now && state_end) begin
      state_d = S_DONE;
      ld_cnt  = 1'b0;
    end
`endif
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      count_q <= '0;
      slot_q  <= '0;
      ucnt_q  <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      if (state_q == S_IDLE && start) count_q <= count;
      if (ld_cnt) ucnt_q <= ld_val;
      else if (!unit_end) ucnt_q <= ucnt_q - CNT_W'(1);
      if (state_q == S_WAIT) slot_q <= '0;
      else if (state_q == S_MARK && unit_end) slot_q <= slot_q + 3'd1;
    end
  end

`ifdef MORSE_PLAYBACK_REPEAT_EN
  always_ff @(posedge clock) begin
    if (reset || !busy_int) stop_req_q <= 1'b0;
    else if (stop) stop_req_q <= 1'b1;
  end
`endif

  // Word shift register: loaded as the RAM data settles, consumed MSB symbol first.
  always_ff @(posedge clock) begin
    if (state_q == S_WAIT) word_q <= rd_data;
    else if (state_q == S_MARK && unit_end) word_q <= {word_q[7:0], 2'b00};
  end

  assign rd_addr = addr_q;
  assign rd_en   = (state_q == S_FETCH);
  assign tone    = (state_q == S_MARK);
  assign symbol  = (state_q == S_MARK) ? word_q[9:8] : 2'b00;
  assign busy    = busy_int;
  assign done    = (state_q == S_DONE);

endmodule

// File: tb/tb_morse_playback.sv
// Bench for morse_playback: per-cycle comparison against a symbol-level timeline model.
module tb_morse_playback;
  localparam int U = 4;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic       stop  = 1'b0;
  logic [3:0] count = 4'd0;
  logic [9:0] rd_data = 10'd0;
  logic [3:0] rd_addr;
  logic       rd_en, tone, busy, done;
  logic [1:0] symbol;

  morse_playback #(.UNIT_CYCLES(U)) dut (
    .clock(clock), .reset(reset), .start(start), .stop(stop), .count(count),
    .rd_data(rd_data), .rd_addr(rd_addr), .rd_en(rd_en), .tone(tone),
    .symbol(symbol), .busy(busy), .done(done)
  );

  always #5 clock = ~clock;

  logic [9:0] mem [16];
  always @(posedge clock) if (rd_en) rd_data <= mem[rd_addr];

  typedef struct packed {
    logic       tone;
    logic [1:0] sym;
    logic       rd;
    logic [3:0] addr;
    logic       busy;
    logic       done;
  } exp_t;

  exp_t exp_q[$];
  int   total = 0;
  int   bad   = 0;
  bit   model_on = 1'b0;

  task automatic chk(input string nm, input int act, input int req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s got=%0d want=%0d at %0t", nm, act, req, $time);
    end
  endtask

  // Timeline of one playback, one entry per cycle starting the cycle after start is taken.
  task automatic push_play(input int cnt);
    exp_t       e;
    logic [9:0] wd;
    logic [1:0] sy;
    for (int w = 0; w < cnt; w++) begin
      wd = mem[w];
      e = '0; e.rd = 1'b1; e.addr = 4'(w); e.busy = 1'b1;
      exp_q.push_back(e);
      e = '0; e.busy = 1'b1;
      exp_q.push_back(e);
      exp_q.push_back(e);
      for (int s = 0; s < 5; s++) begin
        sy = wd[9-2*s -: 2];
        if (sy[0] == 1'b0) break;
        e = '0; e.busy = 1'b1; e.tone = 1'b1; e.sym = sy;
        repeat (((sy == 2'b11) ? 3 : 1) * U) exp_q.push_back(e);
        e = '0; e.busy = 1'b1;
        repeat (U) exp_q.push_back(e);
      end
      e = '0; e.busy = 1'b1;
      repeat (2 * U) exp_q.push_back(e);
    end
    e = '0; e.done = 1'b1;
    exp_q.push_back(e);
  endtask

  always @(negedge clock) begin
    exp_t e;
    if (model_on) begin
      if (exp_q.size() != 0) e = exp_q.pop_front();
      else e = '0;
      chk("tone",   int'(tone),   int'(e.tone));
      chk("symbol", int'(symbol), int'(e.sym));
      chk("rd_en",  int'(rd_en),  int'(e.rd));
      chk("busy",   int'(busy),   int'(e.busy));
      chk("done",   int'(done),   int'(e.done));
      if (e.rd) chk("rd_addr", int'(rd_addr), int'(e.addr));
    end
  end

  task automatic play(input string nm, input int cnt, input int lat_exp, input int rd_exp,
                      input int hi_exp, input bit dbl_start, input bit pulse_stop);
    int lat, reads, hi, mhi;
    bit got;
    @(posedge clock);
    #1 count = 4'(cnt); start = 1'b1;
    @(posedge clock);
    push_play(cnt);
    mhi = 0;
    foreach (exp_q[k]) if (exp_q[k].tone) mhi++;
    chk({nm, "_model_len"}, exp_q.size(), lat_exp);
    chk({nm, "_model_hi"}, mhi, hi_exp);
    #1 start = 1'b0; count = ~4'(cnt);
    lat = 0; reads = 0; hi = 0; got = 1'b0;
    for (int i = 1; i <= 600 && !got; i++) begin
      @(negedge clock);
      if (rd_en) reads++;
      if (tone) hi++;
      if (done) begin got = 1'b1; lat = i; end
      start = dbl_start && (i == 10);
      stop  = pulse_stop && (i == 6);
    end
    start = 1'b0;
    stop  = 1'b0;
    chk({nm, "_done_latency"}, lat, lat_exp);
    chk({nm, "_reads"}, reads, rd_exp);
    chk({nm, "_tone_cycles"}, hi, hi_exp);
    repeat (3) @(posedge clock);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    foreach (mem[k]) mem[k] = 10'd0;
    repeat (3) @(posedge clock);
    @(negedge clock);
    chk("reset_tone",    int'(tone),    0);
    chk("reset_rd_en",   int'(rd_en),   0);
    chk("reset_busy",    int'(busy),    0);
    chk("reset_done",    int'(done),    0);
    chk("reset_symbol",  int'(symbol),  0);
    chk("reset_rd_addr", int'(rd_addr), 0);
    reset = 1'b0;
    model_on = 1'b1;

    // Empty request: immediate done, no read.
    play("count0", 0, 1, 0, 0, 1'b0, 1'b0);

`ifndef MORSE_PLAYBACK_REPEAT_EN
    // Dot then dash, terminated by 00.
    mem[0] = 10'b01_11_00_00_00;
    play("dot_dash", 1, 36, 1, 16, 1'b0, 1'b0);
    // Five dots, then an empty word.
    mem[0] = 10'b01_01_01_01_01;
    mem[1] = 10'b00_00_00_00_00;
    play("five_dots", 2, 63, 2, 20, 1'b0, 1'b0);
    // Code 10 terminates the word even with marks after it.
    mem[0] = 10'b11_01_10_11_11;
    play("term_10", 1, 36, 1, 16, 1'b0, 1'b0);
    // Full word of dashes uses all five slots.
    mem[0] = 10'b11_11_11_11_11;
    play("five_dashes", 1, 92, 1, 60, 1'b0, 1'b0);
    // Second start during busy and a stop pulse are both ignored.
    mem[0] = 10'b01_11_00_00_00;
    play("restart_ign", 1, 36, 1, 16, 1'b1, 1'b0);
    play("stop_ign", 1, 36, 1, 16, 1'b0, 1'b1);
    // count=15: addresses 0..14 only; address 15 holds marks that must never play.
    foreach (mem[k]) mem[k] = 10'd0;
    mem[15] = 10'b11_11_11_11_11;
    play("count15", 15, 166, 15, 0, 1'b0, 1'b0);

    // Reset in the middle of the dash, then replay from address 0.
    mem[0] = 10'b01_11_00_00_00;
    @(posedge clock);
    #1 count = 4'd1; start = 1'b1;
    @(posedge clock);
    push_play(1);
    #1 start = 1'b0;
    repeat (13) @(posedge clock);
    @(negedge clock);
    chk("mid_dash_tone", int'(tone), 1);
    reset = 1'b1;
    @(posedge clock);
    exp_q.delete();
    @(negedge clock);
    chk("after_reset_tone", int'(tone), 0);
    chk("after_reset_busy", int'(busy), 0);
    reset = 1'b0;
    play("replay", 1, 36, 1, 16, 1'b0, 1'b0);
`else
    begin
      int rise[3];
      int nr, lat, reads, hi;
      bit prev, got;
      mem[0] = 10'b01_00_00_00_00;
      model_on = 1'b0;
      @(posedge clock);
      #1 count = 4'd1; start = 1'b1;
      @(posedge clock);
      #1 start = 1'b0;
      nr = 0; lat = 0; reads = 0; hi = 0; prev = 1'b0; got = 1'b0;
      rise[0] = 0; rise[1] = 0; rise[2] = 0;
      for (int i = 1; i <= 400 && !got; i++) begin
        @(negedge clock);
        if (rd_en) reads++;
        if (tone) hi++;
        if (tone && !prev && nr < 3) begin rise[nr] = i; nr++; end
        prev = tone;
        if (done) begin got = 1'b1; lat = i; end
        stop = (i == 95);
      end
      stop = 1'b0;
      chk("rep_first_rise", rise[0], 4);
      chk("rep_period_1", rise[1] - rise[0], 35);
      chk("rep_period_2", rise[2] - rise[1], 35);
      chk("rep_done_latency", lat, 106);
      chk("rep_reads", reads, 3);
      chk("rep_tone_cycles", hi, 12);
      repeat (2) @(posedge clock);
      model_on = 1'b1;
      repeat (4) @(posedge clock);
    end
`endif

    @(negedge clock);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
